// File: rtl/decode_stage.sv
// RV32I decode stage: register-read, immediate extraction, RAW/WAW scoreboard. Latency 1 cycle.
// Holds ex_* while ex_ready_i is low; if_ready_o drops on downstream stall, hazard or flush.
module decode_stage #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGISTER = 32,
   localparam int AW          = $clog2(NUM_REGISTER)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  if_valid_i,
   output logic                  if_ready_o,
   input  logic [31:0]           if_instr_i,
   input  logic [DATA_WIDTH-1:0] if_pc_i,
   output logic [AW-1:0]         rs1_addr_o,
   output logic [AW-1:0]         rs2_addr_o,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic                  wb_we_i,
   input  logic [AW-1:0]         wb_rd_addr_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   input  logic                  flush_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [DATA_WIDTH-1:0] ex_pc_o,
   output logic [DATA_WIDTH-1:0] ex_rs1_o,
   output logic [DATA_WIDTH-1:0] ex_rs2_o,
   output logic [DATA_WIDTH-1:0] ex_imm_o,
   output logic [AW-1:0]         ex_rd_addr_o,
   output logic [6:0]            ex_opcode_o,
   output logic [2:0]            ex_funct3_o,
   output logic                  ex_funct7b5_o,
   output logic                  ex_rd_we_o,
   output logic                  ex_illegal_o
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] rs1;
      logic [DATA_WIDTH-1:0] rs2;
      logic [DATA_WIDTH-1:0] imm;
      logic [AW-1:0]         rd;
      logic [6:0]            opcode;
      logic [2:0]            funct3;
      logic                  funct7b5;
      logic                  rd_we;
      logic                  illegal;
   } ex_t;

   ex_t                    ex_q, ex_d;
   logic                   ex_valid_q;
   logic [NUM_REGISTER-1:1] pending_q;
   logic [NUM_REGISTER-1:0] pend_all;

   logic [31:0]   instr;
   logic [6:0]    opcode;
   logic [AW-1:0] rd, rs1, rs2;
   logic          legal, use_rs1, use_rs2, writes, rd_we_dec;
   logic [31:0]   imm32;
   logic          ex_busy, raw1, raw2, waw, hazard, accept, retire;
   logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

   assign instr      = if_instr_i;
   assign opcode     = instr[6:0];
   assign rd         = AW'(instr[11:7]);
   assign rs1        = AW'(instr[19:15]);
   assign rs2        = AW'(instr[24:20]);
   assign rs1_addr_o = rs1;
   assign rs2_addr_o = rs2;

   always_comb begin
      legal   = 1'b1;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      writes  = 1'b0;
      imm32   = '0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            use_rs1 = 1'b0;
            writes  = 1'b1;
            imm32   = {instr[31:12], 12'b0};
         end
         OPC_JAL: begin
            use_rs1 = 1'b0;
            writes  = 1'b1;
            imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            writes = 1'b1;
            imm32  = {{20{instr[31]}}, instr[31:20]};
         end
         OPC_SYSTEM: imm32 = {{20{instr[31]}}, instr[31:20]};
         OPC_BRANCH: begin
            use_rs2 = 1'b1;
            imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OPC_STORE: begin
            use_rs2 = 1'b1;
            imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OPC_OP: begin
            use_rs2 = 1'b1;
            writes  = 1'b1;
         end
         OPC_MISC: ;
         default: begin
            legal   = 1'b0;
            use_rs1 = 1'b0;
         end
      endcase
   end

   assign rd_we_dec = writes && (rd != '0);

   // A register retiring from writeback this cycle is no longer a RAW source.
   assign pend_all = {pending_q, 1'b0};
   assign ex_busy  = ex_valid_q && ex_q.rd_we;
   assign raw1 = use_rs1 && (rs1 != '0) &&
                 ((pend_all[rs1] && !(wb_we_i && wb_rd_addr_i == rs1)) || (ex_busy && ex_q.rd == rs1));
   assign raw2 = use_rs2 && (rs2 != '0) &&
                 ((pend_all[rs2] && !(wb_we_i && wb_rd_addr_i == rs2)) || (ex_busy && ex_q.rd == rs2));
   assign waw  = rd_we_dec && (pend_all[rd] || (ex_busy && ex_q.rd == rd));
   assign hazard = raw1 || raw2 || waw;

   assign if_ready_o = (!ex_valid_q || ex_ready_i) && !hazard && !flush_i;
   assign accept     = if_valid_i && if_ready_o;
   assign retire     = ex_valid_q && ex_ready_i && !flush_i && ex_q.rd_we;

   always_comb begin
      rs1_val = rs1_data_i;
      rs2_val = rs2_data_i;
      if (rs1 == '0)                                rs1_val = '0;
      else if (wb_we_i && wb_rd_addr_i == rs1)      rs1_val = wb_data_i;
      if (rs2 == '0)                                rs2_val = '0;
      else if (wb_we_i && wb_rd_addr_i == rs2)      rs2_val = wb_data_i;
   end

   always_comb begin
      ex_d          = '0;
      ex_d.pc       = if_pc_i;
      ex_d.rs1      = rs1_val;
      ex_d.rs2      = rs2_val;
      ex_d.imm      = DATA_WIDTH'($signed(imm32));
      ex_d.rd       = rd;
      ex_d.opcode   = opcode;
      ex_d.funct3   = instr[14:12];
      ex_d.funct7b5 = instr[30];
      ex_d.rd_we    = rd_we_dec && legal;
      ex_d.illegal  = !legal;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else begin
         if (flush_i)         ex_valid_q <= 1'b0;
         else if (accept)     ex_valid_q <= 1'b1;
         else if (ex_ready_i) ex_valid_q <= 1'b0;
         if (accept)          ex_q <= ex_d;
      end
   end

   // Set beats clear so a same-cycle writeback cannot hide a newly issued write.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pending_q <= '0;
      end else begin
         for (int i = 1; i < NUM_REGISTER; i++) begin
            if (retire && ex_q.rd == AW'(i))             pending_q[i] <= 1'b1;
            else if (wb_we_i && wb_rd_addr_i == AW'(i))  pending_q[i] <= 1'b0;
         end
      end
   end

   assign ex_valid_o    = ex_valid_q;
   assign ex_pc_o       = ex_q.pc;
   assign ex_rs1_o      = ex_q.rs1;
   assign ex_rs2_o      = ex_q.rs2;
   assign ex_imm_o      = ex_q.imm;
   assign ex_rd_addr_o  = ex_q.rd;
   assign ex_opcode_o   = ex_q.opcode;
   assign ex_funct3_o   = ex_q.funct3;
   assign ex_funct7b5_o = ex_q.funct7b5;
   assign ex_rd_we_o    = ex_q.rd_we;
   assign ex_illegal_o  = ex_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the register and datapath width.
REQ-002 The block SHALL have parameter NUM_REGISTER, default 32, meaning the architectural register count; address width is $clog2(NUM_REGISTER) (AW).
REQ-003 The block SHALL have port clk_i, input, 1, clock.
REQ-004 The block SHALL have port rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have ports if_valid_i (input, 1), if_ready_o (output, 1), if_instr_i (input, 32) and if_pc_i (input, DATA_WIDTH), forming the fetch-side handshake.
REQ-006 The block SHALL have ports rs1_addr_o and rs2_addr_o (output, AW), which drive register-file read addresses combinationally from if_instr_i[19:15] and [24:20].
REQ-007 The block SHALL have ports rs1_data_i and rs2_data_i (input, DATA_WIDTH), carrying register-file read data.
REQ-008 The block SHALL have ports wb_we_i (input, 1), wb_rd_addr_i (input, AW) and wb_data_i (input, DATA_WIDTH), carrying the writeback port that also feeds the register file.
REQ-009 The block SHALL have port flush_i, input, 1, which kills the instruction held in the output register.
REQ-010 The block SHALL have ports ex_valid_o (output, 1) and ex_ready_i (input, 1), forming the execute-side handshake.
REQ-011 The block SHALL have registered outputs ex_pc_o, ex_rs1_o, ex_rs2_o and ex_imm_o (DATA_WIDTH), ex_rd_addr_o (AW), ex_opcode_o (7), ex_funct3_o (3), ex_funct7b5_o (1), ex_rd_we_o (1) and ex_illegal_o (1).

Function
REQ-012 An instruction SHALL be accepted on a cycle when if_valid_i && if_ready_o; all ex_* outputs SHALL load on that clock edge with ex_valid_o=1, giving a latency of 1 cycle.
REQ-013 if_ready_o SHALL equal (!ex_valid_o || ex_ready_i) && !hazard && !flush_i.
REQ-014 When no accept occurs and ex_valid_o && ex_ready_i, ex_valid_o SHALL clear; when ex_valid_o && !ex_ready_i, all ex_* outputs SHALL hold stable.
REQ-015 flush_i SHALL clear ex_valid_o on the next edge, take precedence over accept and hold, and leave the scoreboard unchanged.
REQ-016 ex_imm_o SHALL be sign-extended per format: I (OP-IMM, LOAD, JALR, SYSTEM), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits=0), J (JAL, bit0=0); for OP, ex_imm_o SHALL be 0.
REQ-017 rs1 SHALL be treated as used for all opcodes except LUI, AUIPC and JAL; rs2 SHALL be treated as used only for BRANCH, STORE and OP; ex_rd_we_o SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when rd!=0.
REQ-018 An opcode outside the RV32I base set, or with instr[1:0]!=2'b11, SHALL set ex_illegal_o=1 and ex_rd_we_o=0, and SHALL cause no stall.
REQ-019 The scoreboard SHALL be pending[NUM_REGISTER-1:1]; a bit SHALL be set when ex_valid_o && ex_ready_i && ex_rd_we_o for ex_rd_addr_o, and cleared when wb_we_i for wb_rd_addr_i; if set and clear hit the same register in the same cycle, set SHALL win; pending[0] SHALL be constant 0.
REQ-020 hazard SHALL be asserted when a used source rs!=0 has pending[rs] && !(wb_we_i && wb_rd_addr_i==rs), or when ex_valid_o && ex_rd_we_o && ex_rd_addr_o==rs.
REQ-021 A WAW hazard SHALL be asserted when the decoded instruction writes rd with pending[rd] set, or with ex_rd_addr_o==rd while ex_valid_o && ex_rd_we_o.
REQ-022 Bypass: if wb_we_i && wb_rd_addr_i==rsN && rsN!=0, ex_rsN_o SHALL capture wb_data_i instead of rsN_data_i; a source address of 0 SHALL always capture 0.

Reset
REQ-023 While rst_n_i=0, asynchronously: ex_valid_o=0, all other ex_* outputs=0, and all pending bits=0.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; the first accept after release SHALL proceed with no hazard.

Verification
REQ-025 ADDI x5,x0,-1 (0xFFF00293) with ex_ready_i=1 -> next cycle ex_valid_o=1, ex_imm_o=0xFFFFFFFF, ex_rd_addr_o=5, ex_rd_we_o=1.
REQ-026 ADDI x5, then ADD x6,x5,x5 back-to-back -> if_ready_o=0 until wb_we_i for x5 with wb_data_i=0x1234; in that cycle ADD is accepted and ex_rs1_o=ex_rs2_o=0x1234.
REQ-027 ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> all ex_* outputs stable and if_ready_o=0; on release the instruction transfers and the next one is accepted on the same cycle.
REQ-028 flush_i pulse while ex_valid_o=1 and stalled -> ex_valid_o=0 next cycle and the pending bit for the flushed rd is not set.
REQ-029 Instruction 0x00000000 -> ex_illegal_o=1, ex_rd_we_o=0; BEQ with imm=-4 -> ex_imm_o=0xFFFFFFFC.
REQ-030 rst_n_i low for 1 cycle during a RAW stall -> ex_valid_o=0 immediately; after release, ADD x6,x5,x5 is accepted without stall.
